// File: rtl/syn_tle_pkg.sv
// Shared types and constants for the syn_tle engine and its result drain.
package syn_tle_pkg;

  typedef enum logic {IDLE, DRAIN} drain_state_e;

  localparam int ENGINE_P = 8;
  localparam int ACC_W    = 4 * ENGINE_P;

  function automatic int acc_width(input int p);
    return 4 * p;
  endfunction

  function automatic int drain_beats(input int m, input int n, input int beat);
    return (m * n) / beat;
  endfunction

endpackage

// File: rtl/syn_tle_drain_sat.sv
// One output lane: clamps an accumulator to OUT_W bits, or sign-extends it when OUT_W is wide enough.
module syn_tle_drain_sat import syn_tle_pkg::*; #(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = ACC_W
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [OUT_W-1:0] res,
  output logic                    clamp
);

  if (OUT_W >= IN_W) begin : g_ext
    assign res   = OUT_W'(acc);
    assign clamp = 1'b0;
  end else begin : g_sat
    localparam logic signed [IN_W-1:0] HI = IN_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [IN_W-1:0] LO = ~HI;

    // Result packs the clamp flag above the narrowed value.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [IN_W-1:0] a);
      if (a > HI)      return {1'b1, HI[OUT_W-1:0]};
      else if (a < LO) return {1'b1, LO[OUT_W-1:0]};
      else             return {1'b0, a[OUT_W-1:0]};
    endfunction

    assign {clamp, res} = sat_fn(acc);
  end

endmodule

// File: rtl/syn_tle_drain.sv
// syn_tle_drain: captures a D tile from the engine and streams it row-major, BEAT elements per beat.
// Build option DRAIN_DBUF_EN: ping-pong tile buffers so back-to-back tiles drain without a bubble.
module syn_tle_drain import syn_tle_pkg::*; #(
  parameter int M     = 2,
  parameter int N     = 2,
  parameter int P     = 8,
  parameter int BEAT  = 1,
  parameter int OUT_W = 4 * P
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic signed [4*P-1:0]   D_i [M][N],
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic signed [OUT_W-1:0] data_o [BEAT],
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    last_o,
  output logic                    sat_o
);

  localparam int AW = acc_width(P);
  localparam int NB = drain_beats(M, N, BEAT);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int EW = (M * N > 1) ? $clog2(M * N) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  if (N % BEAT != 0) begin : g_beat_chk
    $error("syn_tle_drain: BEAT must divide N");
  end

  logic                    cap;
  logic                    beat_acc;
  logic                    last_acc;
  logic [CW-1:0]           beat_q;
  logic signed [AW-1:0]    lane_acc [BEAT];
  logic signed [OUT_W-1:0] lane_res [BEAT];
  logic [BEAT-1:0]         lane_clamp;

  assign cap      = valid_i && ready_o;
  assign beat_acc = valid_o && ready_i;
  assign last_acc = beat_acc && (beat_q == LAST_BEAT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       beat_q <= '0;
    else if (last_acc) beat_q <= '0;
    else if (beat_acc) beat_q <= beat_q + 1'b1;
  end

`ifdef DRAIN_DBUF_EN
  logic signed [AW-1:0] tile_q [2][M*N];
  logic                 wr_sel_q;
  logic                 rd_sel_q;
  logic [1:0]           occ_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (cap)      wr_sel_q <= ~wr_sel_q;
      if (last_acc) rd_sel_q <= ~rd_sel_q;
      occ_q <= occ_q + {1'b0, cap} - {1'b0, last_acc};
    end
  end

  // Tile storage is flattened row-major so beat k starts at element k*BEAT.
  always_ff @(posedge clk_i) begin
    if (cap) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          tile_q[wr_sel_q][EW'(i * N + j)] <= D_i[i][j];
    end
  end

  assign ready_o = (occ_q != 2'd2);
  assign valid_o = (occ_q != 2'd0);
`else
  drain_state_e         state_q;
  logic signed [AW-1:0] tile_q [M*N];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cap) begin
          state_q <= DRAIN;
          ready_o <= 1'b0;
          valid_o <= 1'b1;
        end
        DRAIN: if (last_acc) begin
          state_q <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (cap) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          tile_q[EW'(i * N + j)] <= D_i[i][j];
    end
  end
`endif

  // Output stage: lanes read the buffer directly, so data holds while the beat index holds.
  for (genvar l = 0; l < BEAT; l++) begin : g_lane
    logic [EW-1:0] idx;
    assign idx = EW'(int'(beat_q) * BEAT + l);
`ifdef DRAIN_DBUF_EN
    assign lane_acc[l] = tile_q[rd_sel_q][idx];
`else
    assign lane_acc[l] = tile_q[idx];
`endif
    syn_tle_drain_sat #(.IN_W(AW), .OUT_W(OUT_W)) u_sat (
      .acc   (lane_acc[l]),
      .res   (lane_res[l]),
      .clamp (lane_clamp[l])
    );
    assign data_o[l] = valid_o ? lane_res[l] : '0;
  end

  assign last_o = valid_o && (beat_q == LAST_BEAT);
  assign sat_o  = valid_o && (|lane_clamp);

endmodule

// File: tb/tb_syn_tle_drain.sv
// Bench for syn_tle_drain: three configurations share stimulus and are checked against a tile-queue model.
module tb_syn_tle_drain;

`ifdef DRAIN_DBUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam int BW [3] = '{1, 1, 2};
  localparam int OW [3] = '{32, 16, 32};

  logic clk = 1'b0;
  logic rst_n;
  logic valid_i;
  logic ready_i;
  logic signed [31:0] d_i [2][2];

  logic rdy [3];
  logic vld [3];
  logic lst [3];
  logic sat [3];
  logic signed [31:0] data0 [1];
  logic signed [15:0] data1 [1];
  logic signed [31:0] data2 [2];

  int checks = 0;
  int failures = 0;

  longint q [3][$];
  int     k [3];

  always #5 clk = ~clk;

  syn_tle_drain #(.M(2), .N(2), .P(8), .BEAT(1), .OUT_W(32)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .D_i(d_i), .valid_i(valid_i), .ready_o(rdy[0]),
    .data_o(data0), .valid_o(vld[0]), .ready_i(ready_i), .last_o(lst[0]), .sat_o(sat[0]));
  syn_tle_drain #(.M(2), .N(2), .P(8), .BEAT(1), .OUT_W(16)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .D_i(d_i), .valid_i(valid_i), .ready_o(rdy[1]),
    .data_o(data1), .valid_o(vld[1]), .ready_i(ready_i), .last_o(lst[1]), .sat_o(sat[1]));
  syn_tle_drain #(.M(2), .N(2), .P(8), .BEAT(2), .OUT_W(32)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .D_i(d_i), .valid_i(valid_i), .ready_o(rdy[2]),
    .data_o(data2), .valid_o(vld[2]), .ready_i(ready_i), .last_o(lst[2]), .sat_o(sat[2]));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic longint satv(input longint v, input int ow, output bit cl);
    longint hi, lo;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -hi - 1;
    cl = 1'b0;
    if (ow >= 32) return v;
    if (v > hi) begin cl = 1'b1; return hi; end
    if (v < lo) begin cl = 1'b1; return lo; end
    return v;
  endfunction

  // Model: per configuration, a queue of captured tile elements and the index of the beat on show.
  always @(negedge clk) begin
    longint act_d [3][2];
    act_d[0][0] = data0[0];
    act_d[0][1] = 0;
    act_d[1][0] = data1[0];
    act_d[1][1] = 0;
    act_d[2][0] = data2[0];
    act_d[2][1] = data2[1];
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        q[c].delete();
        k[c] = 0;
      end
    end
    for (int c = 0; c < 3; c++) begin
      bit ev, er, el, es, cl;
      longint ed;
      int nb;
      nb = 4 / BW[c];
      ev = (q[c].size() > 0);
      er = (q[c].size() < 4 * CAP);
      el = ev && (k[c] == nb - 1);
      es = 1'b0;
      chk($sformatf("c%0d valid", c), vld[c], ev);
      chk($sformatf("c%0d ready", c), rdy[c], er);
      chk($sformatf("c%0d last", c), lst[c], el);
      for (int l = 0; l < BW[c]; l++) begin
        ed = 0;
        if (ev) begin
          ed = satv(q[c][k[c] * BW[c] + l], OW[c], cl);
          es = es | cl;
        end
        chk($sformatf("c%0d data lane%0d", c, l), act_d[c][l], ed);
      end
      chk($sformatf("c%0d sat", c), sat[c], es);
      if (rst_n) begin
        if (ev && ready_i) begin
          k[c]++;
          if (k[c] == nb) begin
            repeat (4) void'(q[c].pop_front());
            k[c] = 0;
          end
        end
        if (valid_i && er)
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
              q[c].push_back(d_i[i][j]);
      end
    end
  end

  task automatic present(input int a, input int b, input int c, input int e);
    @(posedge clk); #1;
    d_i[0][0] = a; d_i[0][1] = b; d_i[1][0] = c; d_i[1][1] = e;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  initial begin
    longint tmp;
    bit cl;
    longint sv [4];
    bit ss [4];
    sv = '{32767, -32768, 100, -1};
    ss = '{1'b1, 1'b1, 1'b0, 1'b0};
    rst_n = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        d_i[i][j] = '0;

    tmp = satv(40000, 16, cl);
    chk("model clamp hi", tmp, 32767);
    chk("model clamp flag", cl, 1);
    tmp = satv(-40000, 16, cl);
    chk("model clamp lo", tmp, -32768);

    @(negedge clk);
    chk("reset ready", rdy[0], 1);
    chk("reset valid", vld[0], 0);
    chk("reset data", data0[0], 0);
    chk("reset last", lst[0], 0);
    chk("reset sat", sat[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready_i = 1'b1;

    // Basic drain, BEAT=1 and BEAT=2 side by side.
    present(7, 8, 9, 10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1 c0 data", data0[0], 7 + i);
      chk("t1 c0 last", lst[0], i == 3);
      if (i < 2) begin
        chk("t1 c2 lane0", data2[0], 7 + 2 * i);
        chk("t1 c2 lane1", data2[1], 8 + 2 * i);
        chk("t1 c2 last", lst[2], i == 1);
      end
    end
    @(negedge clk);
    chk("t1 ready back", rdy[0], 1);

    // Backpressure while beat 1 is presented.
    present(7, 8, 9, 10);
    @(posedge clk); #1;
    ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold data", data0[0], 8);
      chk("hold valid", vld[0], 1);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("release data", data0[0], 8 + i);
      chk("release last", lst[0], i == 2);
    end

    // Saturation to 16 bits.
    present(40000, -40000, 100, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sat16 data", data1[0], sv[i]);
      chk("sat16 flag", sat[1], ss[i]);
    end

    // Reset after beat 0 has been accepted.
    present(7, 8, 9, 10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst valid", vld[0], 0);
    chk("midrst ready", rdy[0], 1);
    chk("midrst data", data0[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    present(1, 2, 3, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post rst data", data0[0], 1 + i);
    end

`ifdef DRAIN_DBUF_EN
    // Two tiles back to back through the ping-pong buffers.
    @(posedge clk); #1;
    d_i[0][0] = 1; d_i[0][1] = 2; d_i[1][0] = 3; d_i[1][1] = 4;
    valid_i = 1'b1;
    @(posedge clk); #1;
    d_i[0][0] = 5; d_i[0][1] = 6; d_i[1][0] = 7; d_i[1][1] = 8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("dbuf data", data0[0], 1 + i);
      chk("dbuf valid", vld[0], 1);
      chk("dbuf last", lst[0], (i == 3) || (i == 7));
      if (i == 0) begin
        @(posedge clk); #1;
        valid_i = 1'b0;
      end
    end
`endif

    // Randomized traffic with occasional one-cycle resets.
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      rst_n   = ($urandom_range(0, 399) != 0);
      valid_i = ($urandom_range(0, 2) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          d_i[i][j] = $signed($urandom) >>> $urandom_range(0, 24);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid_i = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/syn_tle_drain.md
# syn_tle_drain

Result-side consumer for the `syn_tle` matrix-multiply engine. It accepts a completed D tile (M×N signed 4P-bit accumulators) through the engine's valid/ready output handshake and drives the engine's `ready_i`. It serializes the tile row-major onto a narrow valid/ready stream of BEAT elements per beat, saturating or sign-extending each element to OUT_W bits. It sits between the engine's D output and the downstream writeback/memory stream.

## Interface
- M, 2, tile rows
- N, 2, tile columns
- P, 8, engine input precision; accumulator width is 4*P
- BEAT, 1, elements per output beat; must divide N
- OUT_W, 4*P, output element width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- D_i  in  signed [4*P-1:0] [M][N]  tile from the engine's D_o
- valid_i  in  1  tile valid, from the engine's valid_o
- ready_o  out  1  tile accept, to the engine's ready_i
- data_o  out  signed [OUT_W-1:0] [BEAT]  output beat; lane l holds column c+l
- valid_o  out  1  beat valid
- ready_i  in  1  downstream accept
- last_o  out  1  final beat of the tile
- sat_o  out  1  at least one lane of the current beat saturated

## Operation
- Tile capture occurs on the rising edge where valid_i && ready_o. All of D_i is copied into the tile buffer.
- Beats per tile: NB = M*N/BEAT.
- Beat k carries row r = (k*BEAT)/N and columns c..c+BEAT-1, with c = (k*BEAT)%N.
- Beat index counter: 0..NB-1.
  - Advances on valid_o && ready_i.
  - Wraps to 0 after the beat with last_o=1.
- FSM states: IDLE and DRAIN.
  - IDLE: ready_o=1, valid_o=0. On capture, go to DRAIN with the counter at 0.
  - DRAIN: ready_o=0, valid_o=1. When the last beat is accepted, go to IDLE.
- Width rules:
  - If OUT_W >= 4P, each element is sign-extended.
  - If OUT_W < 4P, each element is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat_o = OR of the per-lane clamp flags for the current beat.
- Hold rule: while valid_o && !ready_i, data_o, last_o and sat_o stay stable.
- Outputs are forced to 0 when valid_o=0: data_o, last_o and sat_o.
- No combinational path from ready_i or valid_i to ready_o or valid_o.

## Timing
- Reset values: ready_o=1, valid_o=0, data_o=0, last_o=0, sat_o=0. Counter=0, state IDLE.
- Latency: tile captured at edge t gives beat 0 valid in cycle t+1.
- With ready_i held high, the last beat is in cycle t+NB. ready_o returns in cycle t+NB+1.
- Single-buffer throughput: one tile per NB+1 cycles.
- Reset asserted mid-drain: the partially drained tile is discarded and all outputs go to their reset values at once. The next tile starts at beat 0.
- valid_i while ready_o=0 is ignored; the engine holds D_o stable per its handshake.

## Configuration
- DRAIN_DBUF_EN defined: two ping-pong tile buffers with a 2-bit occupancy count.
  - ready_o = (occupancy < 2).
  - A capture and an acceptance of the last beat may happen in the same cycle; occupancy is then unchanged.
  - Back-to-back tiles stream with zero bubble: one tile per NB cycles.
  - Tiles leave in capture order.
- DRAIN_DBUF_EN undefined: single buffer with the IDLE/DRAIN behaviour above. No extra buffer flops.

## Structure
- `syn_tle_pkg` holds:
  - the `drain_state_e` enum (IDLE, DRAIN);
  - a `drain_beats(M,N,BEAT)` constant function;
  - the accumulator width constant ACC_W = 4*P.
- Sub-module `syn_tle_drain_sat`: one lane, 4P to OUT_W saturate/sign-extend with a clamp flag. It is instantiated BEAT times.
- Elaboration-time assertion: N % BEAT == 0.

## Test plan
- M=N=2, BEAT=1, OUT_W=32, D={{7,8},{9,10}}, ready_i=1.
  - Beats 7, 8, 9, 10 in cycles t+1..t+4.
  - last_o only on 10.
  - ready_o=1 at t+5.
- Same tile with ready_i=0 for 3 cycles while beat 1 is presented: data_o holds 8 and valid_o stays 1 for all 3 cycles, then 9 and 10 follow.
- OUT_W=16, D={{40000,-40000},{100,-1}}:
  - beats 32767 (sat_o=1), -32768 (sat_o=1), 100 (sat_o=0), -1 (sat_o=0).
- BEAT=2, D={{7,8},{9,10}}: beat 0 = {7,8}, beat 1 = {9,10} with last_o=1.
- Reset pulsed after beat 0 is accepted:
  - valid_o=0 and ready_o=1 at once.
  - The next tile {{1,2},{3,4}} drains as 1, 2, 3, 4.
- DRAIN_DBUF_EN, two tiles offered back-to-back, ready_i=1: 8 beats in 8 consecutive cycles, in order, with last_o on beats 4 and 8.
